// File: rtl/reg_ctx_sequencer_if.sv
// Memory-side request/acknowledge bus used by the register-context sequencer.
interface reg_ctx_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/reg_ctx_sequencer.sv
// Saves r0..rNREGS-1 to a memory frame or restores them from it, stalling the
// core while the transfer runs. One register per acked cycle on save, two on restore.
module reg_ctx_sequencer #(
  parameter int NREGS  = 16,
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 save_start,
  input  logic                 restore_start,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic [3:0]           rf_a_select,
  output logic [3:0]           rf_b_select,
  output logic                 rf_write_en,
  output logic [7:0]           rf_din,
  output logic                 rf_move,
  output logic                 rf_add,
  input  logic [7:0]           rf_outB,
  reg_ctx_sequencer_if.master  mem
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    RESTORE,
    RWRITE,
    DONE
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(NREGS - 1);

  state_e            state_q, state_d;
  logic [3:0]        idx_q,   idx_d;
  logic [ADDR_W-1:0] base_q,  base_d;
  logic [7:0]        din_q,   din_d;
  logic [ADDR_W-1:0] frame_addr;

  // Address arithmetic wraps naturally at 2^ADDR_W.
  assign frame_addr = base_q + ADDR_W'(idx_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      din_q   <= din_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    base_d         = base_q;
    din_d          = din_q;
    busy           = 1'b0;
    done           = 1'b0;
    rf_a_select    = '0;
    rf_b_select    = '0;
    rf_write_en    = 1'b0;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;

    unique case (state_q)
      IDLE: begin
        if (save_start) begin
          idx_d   = '0;
          base_d  = base_addr;
          state_d = SAVE;
        end else if (restore_start) begin
          idx_d   = '0;
          base_d  = base_addr;
          state_d = RESTORE;
        end
      end

      SAVE: begin
        busy          = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = frame_addr;
        rf_b_select   = idx_q;
        mem.mem_wdata = rf_outB;
        if (mem.mem_ack) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 4'd1;
        end
      end

      RESTORE: begin
        busy         = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_addr = frame_addr;
        if (mem.mem_ack) begin
          din_d   = mem.mem_rdata;
          state_d = RWRITE;
        end
      end

      // The captured byte is written while the bus is released, so a restore
      // costs at least two cycles per register.
      RWRITE: begin
        busy        = 1'b1;
        rf_write_en = 1'b1;
        rf_a_select = idx_q;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = RESTORE;
        end
      end

      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign stall   = busy;
  assign rf_din  = din_q;
  assign rf_move = 1'b0;
  assign rf_add  = 1'b0;

endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// Directed bench for reg_ctx_sequencer: register-file and memory models around a
// 16-register instance, plus a 4-register instance for the address-wrap case.
module tb_reg_ctx_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 16-register instance
  logic        save_start = 1'b0, restore_start = 1'b0;
  logic [15:0] base_addr = '0;
  logic        busy, stall, done, rf_write_en, rf_move, rf_add;
  logic [3:0]  rf_a_select, rf_b_select;
  logic [7:0]  rf_din, rf_outB;
  reg_ctx_sequencer_if #(.ADDR_W(16)) mif ();

  reg_ctx_sequencer #(.NREGS(16), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .save_start(save_start), .restore_start(restore_start),
    .base_addr(base_addr), .busy(busy), .stall(stall), .done(done),
    .rf_a_select(rf_a_select), .rf_b_select(rf_b_select), .rf_write_en(rf_write_en),
    .rf_din(rf_din), .rf_move(rf_move), .rf_add(rf_add), .rf_outB(rf_outB), .mem(mif)
  );

  // 4-register instance, always-acked memory, rf_outB = 0x40 + select
  logic        save_start_4 = 1'b0;
  logic [15:0] base_addr_4 = '0;
  logic        busy_4, stall_4, done_4, rf_write_en_4, rf_move_4, rf_add_4;
  logic [3:0]  rf_a_select_4, rf_b_select_4;
  logic [7:0]  rf_din_4, rf_outB_4;
  reg_ctx_sequencer_if #(.ADDR_W(16)) mif4 ();

  reg_ctx_sequencer #(.NREGS(4), .ADDR_W(16)) dut4 (
    .clk(clk), .reset(reset), .save_start(save_start_4), .restore_start(1'b0),
    .base_addr(base_addr_4), .busy(busy_4), .stall(stall_4), .done(done_4),
    .rf_a_select(rf_a_select_4), .rf_b_select(rf_b_select_4), .rf_write_en(rf_write_en_4),
    .rf_din(rf_din_4), .rf_move(rf_move_4), .rf_add(rf_add_4), .rf_outB(rf_outB_4), .mem(mif4)
  );
  assign rf_outB_4       = 8'h40 + {4'h0, rf_b_select_4};
  assign mif4.mem_ack    = 1'b1;
  assign mif4.mem_rdata  = 8'h00;

  // Register-file model
  logic [7:0] rf      [16];
  logic [7:0] rf_init [16];
  logic       rf_load = 1'b0;
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 16; i++) rf[i] <= rf_init[i];
    end else if (rf_write_en) begin
      rf[rf_a_select] <= rf_din;
    end
  end
  assign rf_outB = rf[rf_b_select];

  // Memory model with held or randomly delayed acknowledge
  logic [7:0]  mem      [65536];
  logic [7:0]  mem_init [16];
  logic [15:0] mem_load_addr = '0;
  logic        mem_load = 1'b0;
  logic        ack_hold = 1'b1;
  int          wcnt = 0;
  int          dly  = 0;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[16'(mem_load_addr + 16'(i))] <= mem_init[i];
    end else if (mif.mem_req && mif.mem_ack && mif.mem_we) begin
      mem[mif.mem_addr] <= mif.mem_wdata;
    end
  end
  assign mif.mem_rdata = mem[mif.mem_addr];
  assign mif.mem_ack   = ack_hold | (mif.mem_req && (wcnt == dly));
  always @(posedge clk) begin
    if (!ack_hold && mif.mem_req) begin
      if (mif.mem_ack) begin
        wcnt <= 0;
        dly  <= $urandom_range(0, 5);
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Monitors
  int          done_cnt = 0, we_cnt = 0, we_long = 0, mvadd_cnt = 0, stab_err = 0;
  logic        prev_we = 1'b0, pend = 1'b0, mon_en = 1'b0;
  logic [24:0] snap = '0;
  always @(posedge clk) begin
    if (done) done_cnt++;
    if (rf_write_en) we_cnt++;
    if (rf_write_en && prev_we) we_long++;
    if (rf_move || rf_add) mvadd_cnt++;
    prev_we <= rf_write_en;
    if (mon_en && pend && ({mif.mem_addr, mif.mem_we, mif.mem_wdata} !== snap)) stab_err++;
    pend <= !reset && mif.mem_req && !mif.mem_ack;
    snap <= {mif.mem_addr, mif.mem_we, mif.mem_wdata};
  end

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [47:0] out_vec();
    return {busy, stall, done, rf_a_select, rf_b_select, rf_write_en, rf_din, rf_move,
            rf_add, mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata};
  endfunction

  task automatic load_rf(input logic [7:0] first, input logic [7:0] step);
    for (int i = 0; i < 16; i++) rf_init[i] = first + 8'(step * i);
    rf_load = 1'b1;
    @(negedge clk);
    rf_load = 1'b0;
  endtask

  task automatic load_mem(input logic [15:0] a, input logic [7:0] first);
    mem_load_addr = a;
    for (int i = 0; i < 16; i++) mem_init[i] = first + 8'(i);
    mem_load = 1'b1;
    @(negedge clk);
    mem_load = 1'b0;
  endtask

  // Called on the negedge of cycle 1; returns the cycle index where done was seen.
  task automatic wait_done(input int budget, output int cycles, output bit ok);
    cycles = 1;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    ok = done;
  endtask

  task automatic start_op(input bit is_save, input logic [15:0] base);
    save_start    = is_save;
    restore_start = !is_save;
    base_addr     = base;
    @(negedge clk);
    save_start    = 1'b0;
    restore_start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (out_vec() !== 48'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected %h", out_vec(), 48'h0);
    end
    n_vec++;
    if ({busy_4, done_4, mif4.mem_req, mif4.mem_addr} !== 19'h0) begin
      n_err++; $display("FAIL reset_outputs_4: got %h expected 0", {busy_4, done_4, mif4.mem_req, mif4.mem_addr});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_save();
    int cyc; bit ok;
    load_rf(8'h10, 8'h01);
    ack_hold = 1'b1;
    start_op(1'b1, 16'h2000);
    for (int k = 0; k < 16; k++) begin
      n_vec++;
      if ({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, busy} !==
          {1'b1, 1'b1, 16'h2000 + 16'(k), 8'h10 + 8'(k), 1'b1}) begin
        n_err++; $display("FAIL save_cycle%0d: got req=%b we=%b addr=%h data=%h expected addr=%h data=%h",
                          k + 1, mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata,
                          16'h2000 + 16'(k), 8'h10 + 8'(k));
      end
      @(negedge clk);
    end
    n_vec++;
    if ({done, busy, stall, mif.mem_req} !== 4'b1110) begin
      n_err++; $display("FAIL save_done_cycle17: got done=%b busy=%b stall=%b req=%b expected 1110", done, busy, stall, mif.mem_req);
    end
    @(negedge clk);
    n_vec++;
    if ({done, busy} !== 2'b00) begin
      n_err++; $display("FAIL save_idle_cycle18: got done=%b busy=%b expected 00", done, busy);
    end
    cyc = 0; ok = 1'b1;
  endtask

  task automatic test_restore();
    int cyc; bit ok;
    load_rf(8'h00, 8'h00);
    load_mem(16'h2000, 8'hA0);
    ack_hold = 1'b1;
    we_cnt = 0; we_long = 0; mvadd_cnt = 0;
    start_op(1'b0, 16'h2000);
    n_vec++;
    if ({mif.mem_req, mif.mem_we, mif.mem_addr} !== {1'b1, 1'b0, 16'h2000}) begin
      n_err++; $display("FAIL restore_first_req: got req=%b we=%b addr=%h expected 1 0 2000", mif.mem_req, mif.mem_we, mif.mem_addr);
    end
    @(negedge clk);
    n_vec++;
    if ({rf_write_en, rf_a_select, rf_din, mif.mem_req} !== {1'b1, 4'd0, 8'hA0, 1'b0}) begin
      n_err++; $display("FAIL restore_first_write: got we=%b sel=%h din=%h req=%b expected 1 0 a0 0", rf_write_en, rf_a_select, rf_din, mif.mem_req);
    end
    @(negedge clk);
    wait_done(100, cyc, ok);
    cyc += 2;
    n_vec++;
    if (!ok || cyc != 33) begin
      n_err++; $display("FAIL restore_done_cycle: got ok=%b cycle=%0d expected 1 and 33", ok, cyc);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (rf[i] !== 8'hA0 + 8'(i)) begin
        n_err++; $display("FAIL restore_r%0d: got %h expected %h", i, rf[i], 8'hA0 + 8'(i));
      end
    end
    n_vec++;
    if ({we_cnt, we_long, mvadd_cnt} !== {32'd16, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL restore_we_pulses: got pulses=%0d long=%0d move_add=%0d expected 16 0 0", we_cnt, we_long, mvadd_cnt);
    end
  endtask

  task automatic test_addr_wrap();
    logic [15:0] exp_a [4];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    save_start_4 = 1'b1;
    base_addr_4  = 16'hFFFE;
    @(negedge clk);
    save_start_4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({mif4.mem_req, mif4.mem_we, mif4.mem_addr, mif4.mem_wdata} !==
          {1'b1, 1'b1, exp_a[k], 8'h40 + 8'(k)}) begin
        n_err++; $display("FAIL wrap_addr%0d: got req=%b we=%b addr=%h data=%h expected addr=%h data=%h",
                          k, mif4.mem_req, mif4.mem_we, mif4.mem_addr, mif4.mem_wdata, exp_a[k], 8'h40 + 8'(k));
      end
      @(negedge clk);
    end
    n_vec++;
    if ({done_4, busy_4} !== 2'b11) begin
      n_err++; $display("FAIL wrap_done: got done=%b busy=%b expected 11", done_4, busy_4);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous_start();
    int cyc; bit ok;
    load_rf(8'h60, 8'h03);
    ack_hold = 1'b1;
    done_cnt = 0;
    save_start = 1'b1; restore_start = 1'b1; base_addr = 16'h3000;
    @(negedge clk);
    save_start = 1'b0; restore_start = 1'b0;
    n_vec++;
    if ({mif.mem_req, mif.mem_we} !== 2'b11) begin
      n_err++; $display("FAIL simul_save_wins: got req=%b we=%b expected 11", mif.mem_req, mif.mem_we);
    end
    repeat (2) @(negedge clk);
    restore_start = 1'b1;
    base_addr     = 16'h7000;
    @(negedge clk);
    restore_start = 1'b0;
    wait_done(100, cyc, ok);
    cyc += 3;
    n_vec++;
    if (!ok || cyc != 17) begin
      n_err++; $display("FAIL simul_done_cycle: got ok=%b cycle=%0d expected 1 and 17", ok, cyc);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if ({busy, done_cnt} !== {1'b0, 32'd1}) begin
      n_err++; $display("FAIL simul_one_done: got busy=%b done_pulses=%0d expected 0 and 1", busy, done_cnt);
    end
    for (int i = 0; i < 16; i += 5) begin
      n_vec++;
      if (mem[16'h3000 + 16'(i)] !== 8'h60 + 8'(3 * i)) begin
        n_err++; $display("FAIL simul_mem%0d: got %h expected %h", i, mem[16'h3000 + 16'(i)], 8'h60 + 8'(3 * i));
      end
    end
  endtask

  task automatic test_random_ack();
    int cyc; bit ok;
    load_rf(8'h5A, 8'd37);
    ack_hold = 1'b0;
    stab_err = 0;
    mon_en   = 1'b1;
    start_op(1'b1, 16'h4000);
    wait_done(400, cyc, ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL rand_save_timeout: got done=%b expected 1 within budget", done);
    end
    @(negedge clk);
    load_rf(8'h00, 8'h00);
    start_op(1'b0, 16'h4000);
    wait_done(600, cyc, ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL rand_restore_timeout: got done=%b expected 1 within budget", done);
    end
    @(negedge clk);
    mon_en   = 1'b0;
    ack_hold = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (rf[i] !== 8'h5A + 8'(37 * i)) begin
        n_err++; $display("FAIL rand_r%0d: got %h expected %h", i, rf[i], 8'h5A + 8'(37 * i));
      end
    end
    n_vec++;
    if (stab_err !== 0) begin
      n_err++; $display("FAIL rand_bus_stable: got %0d changes while pending expected 0", stab_err);
    end
  endtask

  task automatic test_reset_mid_restore();
    int cyc; bit ok;
    load_rf(8'h00, 8'h00);
    load_mem(16'h2000, 8'hA0);
    ack_hold = 1'b1;
    start_op(1'b0, 16'h2000);
    repeat (14) @(negedge clk);
    n_vec++;
    if ({mif.mem_req, mif.mem_we, mif.mem_addr} !== {1'b1, 1'b0, 16'h2007}) begin
      n_err++; $display("FAIL midrst_at_r7: got req=%b we=%b addr=%h expected 1 0 2007", mif.mem_req, mif.mem_we, mif.mem_addr);
    end
    done_cnt = 0;
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (out_vec() !== 48'h0) begin
      n_err++; $display("FAIL midrst_async_zero: got %h expected %h", out_vec(), 48'h0);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if ({out_vec(), done_cnt} !== {48'h0, 32'd0}) begin
      n_err++; $display("FAIL midrst_held: got out=%h done_pulses=%0d expected 0 0", out_vec(), done_cnt);
    end
    reset      = 1'b0;
    save_start = 1'b1;
    base_addr  = 16'h5000;
    @(negedge clk);
    save_start = 1'b0;
    n_vec++;
    if ({busy, mif.mem_addr} !== {1'b1, 16'h5000}) begin
      n_err++; $display("FAIL midrst_first_edge_start: got busy=%b addr=%h expected 1 5000", busy, mif.mem_addr);
    end
    wait_done(100, cyc, ok);
    n_vec++;
    if (!ok || cyc != 17) begin
      n_err++; $display("FAIL midrst_save_done: got ok=%b cycle=%0d expected 1 and 17", ok, cyc);
    end
    @(negedge clk);
    n_vec++;
    if (done_cnt !== 1) begin
      n_err++; $display("FAIL midrst_done_count: got %0d expected 1", done_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (mem[16'h5000 + 16'(i)] !== ((i < 7) ? 8'hA0 + 8'(i) : 8'h00)) begin
        n_err++; $display("FAIL midrst_mem%0d: got %h expected %h", i, mem[16'h5000 + 16'(i)],
                          (i < 7) ? 8'hA0 + 8'(i) : 8'h00);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_save();
    test_restore();
    test_addr_wrap();
    test_simultaneous_start();
    test_random_ack();
    test_reset_mid_restore();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_ctx_sequencer.md
REG_CTX_SEQUENCER -- requirements
Module: reg_ctx_sequencer

Interface
REQ-001 The block SHALL provide parameter NREGS, default 16, meaning the number of registers saved or restored (r0..rNREGS-1), legal range 1..16.
REQ-002 The block SHALL provide parameter ADDR_W, default 16, meaning the memory address width.
REQ-003 The block SHALL have exactly one clock, clk (input, 1 bit, rising-edge); all state SHALL be clocked by clk.
REQ-004 The block SHALL have reset (input, 1 bit), which is asynchronous and active-high.
REQ-005 save_start (input, 1 bit) SHALL be a pulse requesting a context save.
REQ-006 restore_start (input, 1 bit) SHALL be a pulse requesting a context restore.
REQ-007 base_addr (input, ADDR_W bits) SHALL be the frame base address, sampled in the start cycle.
REQ-008 busy (output, 1 bit) SHALL indicate that an operation is in progress; stall (output, 1 bit) SHALL equal busy and freeze the CPU core.
REQ-009 done (output, 1 bit) SHALL be a one-cycle completion pulse.
REQ-010 rf_a_select and rf_b_select (outputs, 4 bits each) SHALL be the register-file port selects.
REQ-011 rf_write_en (output, 1 bit) and rf_din (output, 8 bits) SHALL drive the register-file write port; rf_move and rf_add (outputs, 1 bit each) SHALL be held at 0 at all times.
REQ-012 rf_outB (input, 8 bits) SHALL be the register-file port-B read data.
REQ-013 The memory port SHALL consist of mem_req (output, 1 bit), mem_we (output, 1 bit), mem_addr (output, ADDR_W bits), mem_wdata (output, 8 bits), mem_rdata (input, 8 bits) and mem_ack (input, 1 bit).

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, SAVE, RESTORE, RWRITE, DONE.
REQ-015 In IDLE, save_start SHALL load idx=0, latch base_addr and enter SAVE; restore_start alone SHALL do the same but enter RESTORE.
REQ-016 If save_start and restore_start are asserted together in IDLE, save SHALL win.
REQ-017 Starts asserted outside IDLE SHALL be ignored and not queued.
REQ-018 In SAVE, outputs SHALL be: mem_req=1, mem_we=1, mem_addr=base+idx, rf_b_select=idx, mem_wdata=rf_outB (combinational pass-through).
REQ-019 On a SAVE edge with mem_ack=1: if idx==NREGS-1 the FSM SHALL go to DONE; otherwise idx SHALL increment and the FSM SHALL stay in SAVE with mem_req held high.
REQ-020 With mem_ack held high, the save SHALL transfer one register per cycle.
REQ-021 In RESTORE, outputs SHALL be: mem_req=1, mem_we=0, mem_addr=base+idx; on mem_ack=1, mem_rdata SHALL be captured into rf_din and the FSM SHALL go to RWRITE.
REQ-022 In RWRITE, outputs SHALL be: mem_req=0, rf_write_en=1, rf_a_select=idx, rf_din=captured byte; on the next edge the FSM SHALL go to DONE if idx==NREGS-1, else increment idx and return to RESTORE.
REQ-023 The restore SHALL take a minimum of 2 cycles per register.
REQ-024 In DONE, done=1 and busy=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-025 busy SHALL be 1 in SAVE, RESTORE, RWRITE and DONE, and 0 in IDLE.
REQ-026 The address SHALL be base+idx computed modulo 2^ADDR_W, so 0xFFFF+1 wraps to 0x0000.
REQ-027 While waiting, mem_req, mem_addr and mem_we SHALL remain stable until mem_ack.
REQ-028 There SHALL be no timeout; mem_ack SHALL be ignored outside SAVE and RESTORE.
REQ-029 rf_write_en SHALL be asserted only in RWRITE.
REQ-030 Outside SAVE, rf_b_select SHALL be 0; outside RWRITE, rf_a_select SHALL be 0.

Reset
REQ-031 Reset assertion SHALL, at any time including mid-operation, immediately force IDLE, idx=0, latched base=0, rf_din=0, and all outputs to 0 (busy, stall, done, mem_req, mem_we, rf_write_en, selects, address and data).
REQ-032 An operation interrupted by reset SHALL be abandoned and SHALL NOT resume or pulse done.
REQ-033 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-034 Save with base=0x2000, r0..r15=0x10..0x1F and mem_ack held at 1 -> 16 writes to 0x2000..0x200F with data 0x10..0x1F on consecutive cycles, done on cycle 17 after start, busy low on cycle 18.
REQ-035 Restore with base=0x2000, memory holding 0xA0..0xAF and 1-cycle ack -> r0..r15=0xA0..0xAF; exactly 16 rf_write_en pulses, each one cycle long; rf_move and rf_add stay 0 throughout.
REQ-036 Save with base=0xFFFE and NREGS=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-037 save_start and restore_start asserted together -> save runs; restore_start pulsed mid-save is ignored; exactly one done pulse.
REQ-038 Random ack delays of 0-5 cycles -> mem_addr, mem_we and mem_wdata stay stable while mem_req is high and unacked; the final register contents are correct.
REQ-039 Reset asserted during restore of r7 -> all outputs go to 0 asynchronously, no done pulse occurs, and a following save completes normally.
